casez_label_expander: RTL and testbench
=======================================

# casez_label_expander

Programmable wildcard-label table with a sequential label-to-value expander: given a label index, it streams every concrete W-bit value that a priority casez over the table would route to that label. It is the encoder-side counterpart of a casez decoder. Verification benches use it to generate exhaustive stimulus for casez/casex decode logic. Stimulus is emitted in ascending order under a valid/ready handshake, honouring first-match priority: values shadowed by lower-index labels are never emitted.

## Interface
- W, 3: width of case expression and labels
- N, 4: number of table entries; entry 0 has highest priority
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  table write strobe
- cfg_idx  in  $clog2(N)  entry written
- cfg_value  in  W  label value
- cfg_mask  in  W  don't-care mask; 1 = bit ignored (casez z/?)
- req_valid  in  1  expansion request
- req_ready  out  1  high only in IDLE
- req_idx  in  $clog2(N)+1  label index to expand
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_value  out  W  concrete matching value
- out_hit  out  1  1 = out_value is real; 0 = empty-result marker
- out_last  out  1  final beat of the expansion
- busy  out  1  not IDLE

## Operation
- Match rule: v matches entry e iff ((v ^ value[e]) & ~mask[e]) == 0.
- Owned rule: v is emitted for idx iff v matches idx and matches no entry e < idx.
- Table writes take effect on the clock edge and are honoured only when busy=0; writes with busy=1 are dropped.
- Reset values:
  - every table entry: value=0, mask=0
  - state IDLE, req_ready=1, out_valid=0, out_value=0, out_hit=0, out_last=0, busy=0
- FSM:
  - IDLE: req_valid && req_ready accepts a request. Latch idx, clear cand counter and pend_valid, go to SCAN.
  - SCAN: test one candidate cand (0..2^W-1) per cycle.
    - cand owned and pend_valid=0: store cand into pend.
    - cand owned and pend_valid=1: present pend as a beat with out_last=0, store cand as the new pend, go to HOLD.
    - cand == 2^W-1 after evaluation: go to FLUSH.
    - Otherwise increment cand.
  - HOLD: out_valid=1. On out_ready, drop out_valid and return to SCAN with cand+1. If the candidate that caused the beat was 2^W-1, go to FLUSH instead.
  - FLUSH: if pend_valid, emit pend with out_hit=1, out_last=1. Otherwise emit out_hit=0, out_last=1, out_value=0. On out_ready, go to IDLE.
- req_idx >= N: go directly to FLUSH with pend_valid=0, giving a single empty beat.
- Counter width is W+1 bits, so 2^W-1 is reached without wrap ambiguity; cand never wraps to 0 within a request.

## Timing
- Outputs are registered; none combinational from inputs except req_ready, which is a state decode.
- Request accept to first SCAN cycle: 1 cycle.
- Total expansion with out_ready held high: 2^W SCAN cycles + 1 cycle per non-final beat + 1 FLUSH cycle.
- out_value, out_hit and out_last are stable while out_valid=1 && out_ready=0.
- cfg_we in the same cycle as request accept: the write is applied, and the expansion uses the post-write table.
- Async reset mid-expansion: immediately returns to IDLE with all outputs at reset values and the table reinitialised. The partial stream is abandoned with no last beat.

## Structure
- Shared package casez_stim_pkg:
  - typedef label_t: struct of value and mask, W bits each
  - state enum {IDLE, SCAN, HOLD, FLUSH}
  - function match(v, label) returning the match rule above
- One sub-module, casez_owner_check. It is combinational: given cand, the table, and idx, it returns owned. It is also reusable by decoder checkers.

## Test plan
- Table {0:000/000, 1:010/000, 2:110/000, 3:000/111}, request idx 3 → beats 001, 011, 100, 101, 111, with out_last only on 111, all out_hit=1.
- Same table, request idx 1 → single beat 010, out_hit=1, out_last=1.
- Entry 1 = 000/000 (duplicate of entry 0), request idx 1 → single beat out_hit=0, out_last=1.
- Entry 0 = 01x (value 010, mask 001), entry 1 = 0xx (value 000, mask 011), request idx 1 → beats 000, 001, last on 001.
- Backpressure: request idx 3 with out_ready toggling every other cycle → same five values in order, no loss or duplication, beats stable while stalled.
- Other cases:
  - req_idx = N → single empty beat.
  - cfg_we while busy → table unchanged (checked by re-expansion).
  - rst_n pulsed during HOLD → out_valid=0 immediately, busy=0, req_ready=1.

Source files
------------

// File: rtl/casez_stim_pkg.sv
// Shared types and the casez match rule for the label expander and any decoder checkers.
package casez_stim_pkg;

    localparam int LBL_W = 3;
    localparam int LBL_N = 4;

    typedef struct packed {
        logic [LBL_W-1:0] value;
        logic [LBL_W-1:0] mask;
    } label_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    // A mask bit of 1 makes that label bit a don't-care, like casez '?'.
    function automatic logic match(input logic [LBL_W-1:0] v, input label_t lbl);
        return ((v ^ lbl.value) & ~lbl.mask) == '0;
    endfunction

endpackage

// File: rtl/casez_owner_check.sv
// Combinational first-match ownership test: cand belongs to idx only if no
// higher-priority (lower-index) entry would capture it first.
module casez_owner_check
    import casez_stim_pkg::*;
#(
    parameter int N = LBL_N
) (
    input  logic [LBL_W-1:0]   cand,
    input  label_t [N-1:0]     tbl,
    input  logic [$clog2(N):0] idx,
    output logic               owned
);

    logic hit;
    logic shadowed;

    always_comb begin
        hit      = 1'b0;
        shadowed = 1'b0;
        for (int e = 0; e < N; e++) begin
            if (e < int'(idx)) begin
                shadowed = shadowed | match(cand, tbl[e]);
            end else if (e == int'(idx)) begin
                hit = match(cand, tbl[e]);
            end
        end
        // Out-of-range idx never equals an entry, so it owns nothing.
        owned = hit & ~shadowed;
    end

endmodule

// File: rtl/casez_label_expander.sv
// Streams, in ascending order, every value a priority casez over the table routes to one label.
// One owned value is held back in pend so the final beat can carry out_last.
module casez_label_expander
    import casez_stim_pkg::*;
#(
    parameter int W = LBL_W,
    parameter int N = LBL_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [$clog2(N)-1:0] cfg_idx,
    input  logic [W-1:0]         cfg_value,
    input  logic [W-1:0]         cfg_mask,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [$clog2(N):0]   req_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_value,
    output logic                 out_hit,
    output logic                 out_last,
    output logic                 busy
);

    localparam int          IW       = $clog2(N) + 1;
    localparam logic [W:0]  CAND_MAX = {1'b0, {W{1'b1}}};

    state_e            state;
    label_t [N-1:0]    tbl;
    logic [IW-1:0]     idx;
    logic [W:0]        cand;
    logic [W-1:0]      pend;
    logic              pend_valid;
    logic              owned;

    casez_owner_check #(.N(N)) u_owner (
        .cand  (cand[W-1:0]),
        .tbl   (tbl),
        .idx   (idx),
        .owned (owned)
    );

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Writes are accepted only while idle so an expansion sees one consistent table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl <= '0;
        end else if (cfg_we && state == IDLE) begin
            tbl[cfg_idx].value <= cfg_value;
            tbl[cfg_idx].mask  <= cfg_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cand       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_value  <= '0;
            out_hit    <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        idx        <= req_idx;
                        cand       <= '0;
                        pend_valid <= 1'b0;
                        if (req_idx >= IW'(N)) begin
                            state     <= FLUSH;
                            out_valid <= 1'b1;
                            out_value <= '0;
                            out_hit   <= 1'b0;
                            out_last  <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (owned && pend_valid) begin
                        out_valid <= 1'b1;
                        out_value <= pend;
                        out_hit   <= 1'b1;
                        out_last  <= 1'b0;
                        pend      <= cand[W-1:0];
                        state     <= HOLD;
                    end else begin
                        if (owned) begin
                            pend       <= cand[W-1:0];
                            pend_valid <= 1'b1;
                        end
                        if (cand == CAND_MAX) begin
                            state     <= FLUSH;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                            out_hit   <= owned | pend_valid;
                            out_value <= owned ? cand[W-1:0] : (pend_valid ? pend : '0);
                        end else begin
                            cand <= cand + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (cand == CAND_MAX) begin
                            state     <= FLUSH;
                            out_valid <= 1'b1;
                            out_value <= pend;
                            out_hit   <= 1'b1;
                            out_last  <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            cand      <= cand + 1'b1;
                            state     <= SCAN;
                        end
                    end
                end
                FLUSH: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_value <= '0;
                        out_hit   <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_casez_label_expander.sv
// Scoreboard bench: expected beats come from a first-match model over a shadow copy of the table.
module tb_casez_label_expander;

    typedef struct packed {
        logic [2:0] v;
        logic       hit;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [2:0] cfg_value = '0;
    logic [2:0] cfg_mask = '0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_idx = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_value;
    logic       out_hit;
    logic       out_last;
    logic       busy;

    int    checks = 0;
    int    errors = 0;
    int    tv[4];
    int    tm[4];
    int    rdy_mode = 0;
    beat_t sb[$];

    casez_label_expander dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_value (cfg_value),
        .cfg_mask  (cfg_mask),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_hit   (out_hit),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Value v is routed to idx by a priority casez iff idx is the first entry it matches.
    function automatic bit owns(input int v, input int idx);
        int first = -1;
        for (int e = 3; e >= 0; e--)
            if (((v ^ tv[e]) & ~tm[e] & 7) == 0) first = e;
        return first == idx;
    endfunction

    task automatic push_expected(input int idx);
        int    hits[$];
        beat_t b;
        for (int v = 0; v < 8; v++)
            if (owns(v, idx)) hits.push_back(v);
        if (hits.size() == 0) begin
            b.v = 3'd0; b.hit = 1'b0; b.last = 1'b1;
            sb.push_back(b);
        end else begin
            for (int k = 0; k < hits.size(); k++) begin
                b.v = 3'(hits[k]); b.hit = 1'b1; b.last = (k == hits.size() - 1);
                sb.push_back(b);
            end
        end
    endtask

    // out_ready pattern: 0 = always, 1 = toggling, 2 = random, 3 = stalled.
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pops on each accepted beat and checks stability while stalled.
    initial begin
        beat_t held;
        beat_t got;
        bit    stalled = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                got = {out_value, out_hit, out_last};
                if (out_valid && stalled) chk("stall_stable", int'(got), int'(held));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", int'(got), -1);
                    end else begin
                        chk("beat", int'(got), int'(sb.pop_front()));
                    end
                end
                stalled = out_valid && !out_ready;
                held    = got;
            end
        end
    end

    task automatic wr(input int i, input int v, input int m, input bit model);
        cfg_we = 1'b1; cfg_idx = 2'(i); cfg_value = 3'(v); cfg_mask = 3'(m);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (model) begin tv[i] = v; tm[i] = m; end
    endtask

    task automatic issue(input int idx);
        int k = 0;
        while (!req_ready && k < 100) begin @(posedge clk); #1; k++; end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        push_expected(idx);
        req_valid = 1'b1; req_idx = 3'(idx);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (!busy && sb.size() == 0) done = 1;
            else begin @(posedge clk); #1; end
        end
        if (!done) begin
            chk("expansion_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic load_plan_table();
        wr(0, 3'b000, 3'b000, 1);
        wr(1, 3'b010, 3'b000, 1);
        wr(2, 3'b110, 3'b000, 1);
        wr(3, 3'b000, 3'b111, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin tv[i] = 0; tm[i] = 0; end
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_value", int'(out_value), 0);
        chk("rst_out_hit", int'(out_hit), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset table: entry 0 = all don't-care-free 000, so idx 0 owns only 000.
        issue(0); wait_done();

        load_plan_table();
        issue(3); wait_done();
        issue(1); wait_done();
        wr(1, 3'b000, 3'b000, 1);
        issue(1); wait_done();
        wr(0, 3'b010, 3'b001, 1);
        wr(1, 3'b000, 3'b011, 1);
        issue(1); wait_done();

        load_plan_table();
        rdy_mode = 1;
        issue(3); wait_done();
        rdy_mode = 0;
        issue(4); wait_done();

        // Write while busy must be dropped; the re-expansion proves the table is unchanged.
        rdy_mode = 1;
        issue(3);
        wr(3, 3'b111, 3'b000, 0);
        wait_done();
        rdy_mode = 0;
        issue(3); wait_done();

        // Write in the accept cycle is applied before the expansion starts.
        tv[3] = 3'b100; tm[3] = 3'b011;
        push_expected(3);
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_value = 3'b100; cfg_mask = 3'b011;
        req_valid = 1'b1; req_idx = 3'd3;
        @(posedge clk); #1;
        cfg_we = 1'b0; req_valid = 1'b0;
        wait_done();

        for (int it = 0; it < 30; it++) begin
            for (int e = 0; e < 4; e++)
                wr(e, int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7) & $urandom_range(0, 7)), 1);
            rdy_mode = int'($urandom_range(0, 2));
            issue(int'($urandom_range(0, 4)));
            wait_done();
        end
        rdy_mode = 0;

        // Async reset while a beat is held: outputs clear at once, partial stream abandoned.
        load_plan_table();
        rdy_mode = 3;
        @(posedge clk); #1;
        issue(3);
        for (int k = 0; k < 50 && !out_valid; k++) begin @(posedge clk); #1; end
        chk("hold_reached", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_req_ready", int'(req_ready), 1);
        chk("mid_rst_out_last", int'(out_last), 0);
        sb.delete();
        for (int i = 0; i < 4; i++) begin tv[i] = 0; tm[i] = 0; end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk); #1;
        issue(0); wait_done();
        issue(2); wait_done();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
